// File: rtl/hilo_div_ctrl.sv
// HI/LO divide sequencer: radix-2 restoring divider with one quotient bit per cycle.
// It stalls the front of the pipeline while it runs and returns {HI=remainder, LO=quotient}.
module hilo_div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               startE,
   input  logic               signed_divE,
   input  logic               annulE,
   input  logic [WIDTH-1:0]   opaE,
   input  logic [WIDTH-1:0]   opbE,
   output logic               stall_divE,
   output logic               readyE,
   output logic [2*WIDTH-1:0] resultE,
   output logic               busyE
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DZERO = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0]   bmag_q, bmag_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic               stall;

   logic               start_ok;
   logic [WIDTH-1:0]   amag, bmag;
   logic [WIDTH:0]     top, trial;
   logic [WIDTH-1:0]   quo, rmd;

   assign start_ok = startE & ~annulE;
   assign amag     = (signed_divE & opaE[WIDTH-1]) ? -opaE : opaE;
   assign bmag     = (signed_divE & opbE[WIDTH-1]) ? -opbE : opbE;

   // Remainder half shifted left with the next dividend bit; the trial borrow sits in bit WIDTH.
   assign top   = rem_q[2*WIDTH-1:WIDTH-1];
   assign trial = top - {1'b0, bmag_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      bmag_d  = bmag_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               stall   = 1'b1;
               state_d = (opbE == '0) ? DZERO : RUN;
               cnt_d   = '0;
               rem_d   = {{WIDTH{1'b0}}, amag};
               bmag_d  = bmag;
               negq_d  = signed_divE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
               negr_d  = signed_divE & opaE[WIDTH-1];
            end
         end
         DZERO: begin
            stall = 1'b1;
            if (annulE) begin
               state_d = IDLE;
            end else begin
               // HI re-signs |opa| back to the original dividend; LO is forced to all ones.
               state_d = DONE;
               rem_d   = {rem_q[WIDTH-1:0], {WIDTH{1'b1}}};
               negq_d  = 1'b0;
            end
         end
         RUN: begin
            stall = 1'b1;
            if (annulE) begin
               state_d = IDLE;
            end else begin
               if (!trial[WIDTH]) begin
                  rem_d = {trial[WIDTH-1:0], rem_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = {top[WIDTH-1:0], rem_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(WIDTH - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign quo   = rem_d[WIDTH-1:0];
   assign rmd   = rem_d[2*WIDTH-1:WIDTH];
   // The result register loads on entry to DONE so it is valid during the ready cycle.
   assign res_d = (state_d == DONE) ? {(negr_d ? -rmd : rmd), (negq_d ? -quo : quo)} : res_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         bmag_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         bmag_q  <= bmag_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
      end
   end

   assign stall_divE = stall & rst;
   assign readyE     = (state_q == DONE);
   assign busyE      = (state_q != IDLE);
   assign resultE    = res_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: table of divides plus abort, reset and back-to-back sequences.
module tb_hilo_div_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        startE = 1'b0;
   logic        signed_divE = 1'b0;
   logic        annulE = 1'b0;
   logic [31:0] opaE = '0;
   logic [31:0] opbE = '0;
   logic        stall_divE;
   logic        readyE;
   logic [63:0] resultE;
   logic        busyE;

   int n_vec = 0;
   int n_err = 0;

   hilo_div_ctrl #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .startE      (startE),
      .signed_divE (signed_divE),
      .annulE      (annulE),
      .opaE        (opaE),
      .opbE        (opbE),
      .stall_divE  (stall_divE),
      .readyE      (readyE),
      .resultE     (resultE),
      .busyE       (busyE)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      int          lat;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%h", name, act);
      end
   endtask

   task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp);
      int          rdy_at = -1;
      int          n_rdy = 0;
      int          n_stall = 0;
      logic [63:0] res_at = '0;
      @(negedge clk);
      startE = 1'b1; signed_divE = sg; opaE = a; opbE = b;
      #1;
      if (stall_divE) n_stall++;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         startE = 1'b0; signed_divE = $urandom_range(1, 0) == 1; opaE = $urandom; opbE = $urandom;
         #1;
         if (stall_divE) n_stall++;
         if (readyE) begin
            n_rdy++;
            if (rdy_at < 0) begin
               rdy_at = k;
               res_at = resultE;
            end
         end
      end
      check({name, " ready cycle"}, 64'(rdy_at), 64'(lat));
      check({name, " ready pulses"}, 64'(n_rdy), 64'd1);
      check({name, " stall cycles"}, 64'(n_stall), 64'(lat));
      check({name, " result"}, res_at, exp);
      check({name, " idle after"}, 64'(busyE), 64'd0);
   endtask

   initial begin
      int n_rdy;
      int t1;
      int t2;

      tbl[0] = '{"DIVU 100/7",       1'b0, 32'd100,      32'd7,        {32'h00000002, 32'h0000000E}, 33};
      tbl[1] = '{"DIV -7/2",         1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
      tbl[2] = '{"DIV 7/-2",         1'b1, 32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33};
      tbl[3] = '{"DIV min/-1",       1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33};
      tbl[4] = '{"DIVU 5/0",         1'b0, 32'd5,        32'd0,        {32'h00000005, 32'hFFFFFFFF}, 2};
      tbl[5] = '{"DIVU max/1",       1'b0, 32'hFFFFFFFF, 32'h00000001, {32'h00000000, 32'hFFFFFFFF}, 33};
      tbl[6] = '{"DIVU 8000../max",  1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 33};
      tbl[7] = '{"DIV -100/-7",      1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 33};
      tbl[8] = '{"DIVU 3/5",         1'b0, 32'd3,        32'd5,        {32'h00000003, 32'h00000000}, 33};
      tbl[9] = '{"DIVU deadbeef/16", 1'b0, 32'hDEADBEEF, 32'h00000010, {32'h0000000F, 32'h0DEADBEE}, 33};

      // Reset held with a start request present: nothing may move or stall.
      startE = 1'b1; opaE = 32'd9; opbE = 32'd3;
      repeat (3) @(negedge clk);
      #1;
      check("reset stall", 64'(stall_divE), 64'd0);
      check("reset busy", 64'(busyE), 64'd0);
      check("reset ready", 64'(readyE), 64'd0);
      check("reset result", resultE, 64'd0);
      startE = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_div(tbl[i].name, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].res);
      end

      // annulE in cycle 10 of a running divide.
      @(negedge clk);
      startE = 1'b1; signed_divE = 1'b0; opaE = 32'd100; opbE = 32'd7;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         startE = 1'b0;
      end
      annulE = 1'b1;
      @(negedge clk);
      annulE = 1'b0;
      #1;
      check("annul busy", 64'(busyE), 64'd0);
      check("annul stall", 64'(stall_divE), 64'd0);
      n_rdy = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (readyE) n_rdy++;
      end
      check("annul ready pulses", 64'(n_rdy), 64'd0);
      check("annul result held", resultE, tbl[9].res);

      // Reset dropped in cycle 20 clears everything at once.
      @(negedge clk);
      startE = 1'b1; opaE = 32'd100; opbE = 32'd7;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         startE = 1'b0;
      end
      #1 rst = 1'b0;
      #1;
      check("midreset busy", 64'(busyE), 64'd0);
      check("midreset stall", 64'(stall_divE), 64'd0);
      check("midreset result", resultE, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      n_rdy = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (readyE) n_rdy++;
      end
      check("midreset ready pulses", 64'(n_rdy), 64'd0);
      check("midreset busy after", 64'(busyE), 64'd0);

      // Back-to-back: start held through DONE is ignored, accepted on the following IDLE cycle.
      @(negedge clk);
      startE = 1'b1; signed_divE = 1'b0; opaE = 32'd9; opbE = 32'd3;
      t1 = -1;
      for (int k = 1; k <= 40 && t1 < 0; k++) begin
         @(negedge clk);
         #1;
         if (readyE) t1 = k;
         else startE = 1'b0;
      end
      check("b2b first ready cycle", 64'(t1), 64'd33);
      check("b2b first result", resultE, {32'd0, 32'd3});
      startE = 1'b1; opaE = 32'd10; opbE = 32'd4;
      @(negedge clk);
      #1;
      check("b2b idle start stall", 64'(stall_divE), 64'd1);
      t2 = -1;
      for (int k = t1 + 2; k <= t1 + 45 && t2 < 0; k++) begin
         @(negedge clk);
         startE = 1'b0;
         #1;
         if (readyE) t2 = k;
      end
      check("b2b ready spacing", 64'(t2 - t1), 64'd34);
      check("b2b second result", resultE, {32'd2, 32'd2});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Multi-cycle divide sequencer for the HI/LO path of the 5-stage MIPS pipeline. It accepts a DIV/DIVU from the execute stage and runs a radix-2 restoring shift-subtract divider, one quotient bit per cycle. While the divide runs it holds the front of the pipeline stalled. When finished it presents a 64-bit {HI,LO} result for the execute-stage HI/LO write.

## Interface
- WIDTH, 32, operand width; the result is 2*WIDTH.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- startE  in  1  a divide instruction is in EX and is not flushed.
- signed_divE  in  1  1 = DIV (signed), 0 = DIVU; sampled when a start is accepted.
- annulE  in  1  flush of EX (exception or branch cancel); aborts any divide.
- opaE  in  WIDTH  dividend (rs); sampled when a start is accepted.
- opbE  in  WIDTH  divisor (rt); sampled when a start is accepted.
- stall_divE  out  1  stall request to the hazard unit; freezes F, D and E.
- readyE  out  1  one-cycle pulse: resultE is valid this cycle.
- resultE  out  2*WIDTH  {HI=remainder, LO=quotient}.
- busyE  out  1  state is not IDLE.

## Operation
- States: IDLE, DZERO, RUN, DONE, encoded in 2 bits.
- IDLE
  - If startE & ~annulE and opbE==0: go to DZERO.
  - If startE & ~annulE and opbE!=0: go to RUN.
  - Otherwise stay in IDLE.
  - On start: latch the signed flag and the operand magnitudes. Signed operands use |x| via two's-complement negate; 0x80000000 stays 0x80000000 as an unsigned magnitude.
  - On start: latch neg_q = signed & (opa[MSB]^opb[MSB]) and neg_r = signed & opa[MSB].
  - On start: clear the 6-bit counter and load the partial remainder with {WIDTH'b0, |opa|}.
- RUN
  - Each cycle: trial = rem_hi(shifted left 1, with the next dividend bit) − |opb| at WIDTH+1 bits.
  - If trial is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - The counter increments; after the step with counter==WIDTH−1, go to DONE.
- DZERO: one filler cycle, then go to DONE. The result is forced to {HI=opa, LO=all ones}.
- DONE
  - readyE=1.
  - resultE gets sign-fixed values: LO = neg_q ? −q : q; HI = neg_r ? −r : r.
  - Unconditionally return to IDLE.
- annulE in RUN or DZERO: go to IDLE next cycle. No readyE pulse; resultE is unchanged.
- annulE in DONE: readyE still pulses. The pipeline discards the result, since the flush kills the HI/LO write.
- startE in DONE is ignored. startE in IDLE on the cycle after DONE is a new divide, so back-to-back is legal.
- stall_divE = (IDLE & startE & ~annulE) | RUN | DZERO. It is 0 in DONE, so the divide instruction advances on the ready cycle.
- resultE is a register. It holds its last value until the next DONE.

## Timing
- Reset (rst=0):
  - State goes to IDLE; the counter, partial remainder, flags and resultE clear to 0.
  - readyE=0, busyE=0.
  - stall_divE is forced to 0 while rst=0.
- Nonzero divisor, start accepted in cycle 0:
  - RUN occupies cycles 1..WIDTH (32 cycles).
  - DONE and readyE in cycle WIDTH+1 (cycle 33).
  - stall_divE is high in cycles 0..32.
- Zero divisor: DZERO in cycle 1, readyE in cycle 2, stall_divE high in cycles 0..1.
- Reset asserted mid-divide aborts immediately, asynchronously. No readyE follows the release of reset.
- Operand inputs are don't-care after the start cycle.

## Test plan
- DIVU 100/7, start at cycle 0:
  - stall_divE high for cycles 0..32.
  - readyE at cycle 33 with resultE = {0x00000002, 0x0000000E}.
- DIV −7/2 (0xFFFFFFF9, 0x00000002): LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/−2: LO=0xFFFFFFFD, HI=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, readyE at cycle 33.
- DIVU 5/0: DZERO at cycle 1, readyE at cycle 2, resultE = {0x00000005, 0xFFFFFFFF}, stall_divE high for 2 cycles.
- Abort cases:
  - annulE at cycle 10 of a divide: IDLE at cycle 11, no readyE, resultE keeps its previous value.
  - rst low at cycle 20: outputs clear immediately; after release, IDLE with no readyE.
- Back-to-back: DIVU 9/3 then, on the cycle after its DONE, DIVU 10/4 with startE held. The second readyE is 34 cycles after the first, with results {0,3} then {2,2}.
